// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide engine with its own sequencer.
// Multiply uses radix-2 Booth steps and divide uses restoring steps on the
// operand magnitudes. Both run one iteration per clock on a shared
// 2*WIDTH-bit accumulator.
// Optional feature macro: MULTDIV_EARLY_OUT_EN. When it is defined, a zero
// operand skips the iterations and the engine goes straight to result fix-up.
module multdiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int unsigned      ACC_W     = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic             q_m1;
    logic [WIDTH-1:0] operand;    // multiplicand (MULT) or |divisor| (DIV)
    logic             is_div;
    logic             neg_q;
    logic             div_zero;
    logic             div_ovf;

    logic             start;
    logic             early;
    logic [WIDTH:0]   booth_sum;
    logic [ACC_W-1:0] booth_next;
    logic [ACC_W-1:0] div_shift;
    logic [WIDTH:0]   trial;
    logic [ACC_W-1:0] div_next;
    logic [WIDTH-1:0] quot;
    logic [WIDTH:0]   prod_top;
    logic             mult_ovf;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'((~x) + WIDTH'(1)) : x;
    endfunction

    // Next-iteration datapath for both algorithms and the result fix-up terms
    always_comb begin
        start = ctrl_MULT | ctrl_DIV;

        // Booth: add/subtract on a sign-extended high word, then arithmetic shift
        booth_sum = {acc[ACC_W-1], acc[ACC_W-1:WIDTH]};
        case ({acc[0], q_m1})
            2'b01:   booth_sum = booth_sum + {operand[WIDTH-1], operand};
            2'b10:   booth_sum = booth_sum - {operand[WIDTH-1], operand};
            default: booth_sum = {acc[ACC_W-1], acc[ACC_W-1:WIDTH]};
        endcase
        booth_next = {booth_sum[WIDTH:1], booth_sum[0], acc[WIDTH-1:1]};

        // Restoring divide: shift, trial subtract, keep or restore remainder
        div_shift = {acc[ACC_W-2:0], 1'b0};
        trial     = {1'b0, div_shift[ACC_W-1:WIDTH]} - {1'b0, operand};
        div_next  = trial[WIDTH] ? div_shift
                                 : {trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

        quot     = neg_q ? WIDTH'((~acc[WIDTH-1:0]) + WIDTH'(1)) : acc[WIDTH-1:0];
        prod_top = acc[ACC_W-1:WIDTH-1];
        mult_ovf = ~((&prod_top) | ~(|prod_top));

        early = 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
        if (ctrl_MULT) begin
            early = (data_operandA == '0) || (data_operandB == '0);
        end else begin
            early = (data_operandB == '0);
        end
`endif
    end

    // Sequencer: a start pulse always wins and aborts any in-flight operation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            count          <= '0;
            acc            <= '0;
            q_m1           <= 1'b0;
            operand        <= '0;
            is_div         <= 1'b0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (start) begin
            count          <= '0;
            q_m1           <= 1'b0;
            busy           <= 1'b1;
            data_resultRDY <= 1'b0;
            neg_q          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero       <= (data_operandB == '0);
            div_ovf        <= (data_operandA == MOST_NEG) && (data_operandB == '1);
            if (ctrl_MULT) begin
                is_div  <= 1'b0;
                operand <= data_operandA;
                acc     <= early ? '0 : {{WIDTH{1'b0}}, data_operandB};
                state   <= early ? S_FIX : S_MULT;
            end else begin
                is_div  <= 1'b1;
                operand <= abs_val(data_operandB);
                acc     <= {{WIDTH{1'b0}}, abs_val(data_operandA)};
                state   <= early ? S_FIX : S_DIV;
            end
        end else begin
            case (state)
                S_MULT: begin
                    acc   <= booth_next;
                    q_m1  <= acc[0];
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) state <= S_FIX;
                end
                S_DIV: begin
                    acc   <= div_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) state <= S_FIX;
                end
                S_FIX: begin
                    if (!is_div) begin
                        data_result    <= acc[WIDTH-1:0];
                        data_exception <= mult_ovf;
                    end else if (div_zero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else if (div_ovf) begin
                        data_result    <= MOST_NEG;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= quot;
                        data_exception <= 1'b0;
                    end
                    data_resultRDY <= 1'b1;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: a directed vector table, hand-written
// multi-cycle sequences (abort, start during DONE, async reset) and random
// operations checked against an arithmetic reference model.
module tb_multdiv_seq;
    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
        string       name;
    } vec_t;

    multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: full-precision signed arithmetic
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    // Edges from the start edge to the edge that raises data_resultRDY
    function automatic int exp_latency(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = 33;
`ifdef MULTDIV_EARLY_OUT_EN
        if (is_div ? (b == 32'h0) : (a == 32'h0 || b == 32'h0)) lat = 1;
`endif
        return lat;
    endfunction

    // Drive a one-cycle start pulse; returns at the falling edge after the start edge
    task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Wait (bounded) for data_resultRDY, noting whether busy stayed high throughout
    task automatic wait_rdy(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (data_resultRDY) break;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e, input string tag);
        int lat;
        bit busy_ok;
        start_op(is_div, a, b);
        wait_rdy(lat, busy_ok);
        check({tag, " latency"}, 32'(lat), 32'(exp_latency(is_div, a, b)));
        check({tag, " result"}, data_result, exp_r);
        check({tag, " exception"}, 32'(data_exception), 32'(exp_e));
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
        @(negedge clock);
        check({tag, " rdy one cycle"}, 32'(data_resultRDY), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        int          lat;
        int          rdy_count;
        bit          busy_ok;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] er;
        logic        ee;
        bit          rdiv;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;

        vecs.push_back('{1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mult 7*-3"});
        vecs.push_back('{1'b0, 32'h4000_0000, 32'd2,         32'h8000_0000, 1'b1, "mult ovf sign"});
        vecs.push_back('{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b1, "mult ovf hi"});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, "mult minneg*1"});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mult minneg*-1"});
        vecs.push_back('{1'b0, 32'h0,         32'd12345,     32'h0,         1'b0, "mult 0*x"});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div -7/2"});
        vecs.push_back('{1'b1, 32'd5,         32'd0,         32'h0,         1'b1, "div 5/0"});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div minneg/-1"});
        vecs.push_back('{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4,         1'b0, "div -8/-2"});
        vecs.push_back('{1'b1, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0, "div max/1"});
        vecs.push_back('{1'b1, 32'h0,         32'd5,         32'h0,         1'b0, "div 0/5"});
        vecs.push_back('{1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div 100/-7"});

        repeat (2) @(negedge clock);
        check("reset result", data_result, 32'h0);
        check("reset exception", 32'(data_exception), 32'd0);
        check("reset rdy", 32'(data_resultRDY), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        foreach (vecs[i]) begin
            do_op(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, vecs[i].name);
        end

        // Both starts together: multiply takes priority (6*3, not 6/3)
        data_operandA = 32'd6;
        data_operandB = 32'd3;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        wait_rdy(lat, busy_ok);
        check("both ctrls latency", 32'(lat), 32'd33);
        check("both ctrls result", data_result, 32'd18);
        @(negedge clock);

        // Abort: multiply interrupted by a divide ten cycles later
        start_op(1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_rdy(lat, busy_ok);
        check("pre-abort result", data_result, 32'hFFFF_FFF2);
        @(negedge clock);
        start_op(1'b0, 32'd3, 32'd4);
        check("result holds on start", data_result, 32'hFFFF_FFF2);
        rdy_count = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) rdy_count++;
        end
        start_op(1'b1, 32'd100, 32'd7);
        wait_rdy(lat, busy_ok);
        check("abort latency", 32'(lat), 32'd33);
        check("abort result", data_result, 32'd14);
        check("abort busy", 32'(busy_ok), 32'd1);
        repeat (10) begin
            @(negedge clock);
            if (data_resultRDY) rdy_count++;
        end
        check("abort extra rdy", 32'(rdy_count), 32'd0);

        // Start during DONE: the pulse completes and the new operation runs
        start_op(1'b0, 32'd5, 32'd6);
        wait_rdy(lat, busy_ok);
        check("done-start first result", data_result, 32'd30);
        start_op(1'b1, 32'd100, 32'd7);
        check("done-start rdy cleared", 32'(data_resultRDY), 32'd0);
        check("done-start busy held", 32'(busy), 32'd1);
        wait_rdy(lat, busy_ok);
        check("done-start latency", 32'(lat), 32'd33);
        check("done-start result", data_result, 32'd14);
        @(negedge clock);
        check("done-start busy after", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation
        start_op(1'b0, 32'd3, 32'd4);
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async reset result", data_result, 32'h0);
        check("async reset rdy", 32'(data_resultRDY), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_count = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_count++;
        end
        check("no rdy after reset", 32'(rdy_count), 32'd0);
        do_op(1'b0, 32'd2, 32'd2, 32'd4, 1'b0, "mult 2*2 after reset");

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rdiv = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 3))
                1: rb = rb >> $urandom_range(8, 31);
                2: ra = ra >> $urandom_range(8, 31);
                3: if ($urandom_range(0, 3) == 0) rb = 32'h0;
                default: ;
            endcase
            model(rdiv, ra, rb, er, ee);
            do_op(rdiv, ra, rb, er, ee, rdiv ? "rand div" : "rand mult");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
